// File: rtl/fetch_unit.sv
// PC and fetch sequencer for the SNACKS core: IDLE/RUN/DONE lifecycle with table-driven redirects.
// Optional PC overflow trap is enabled by defining FETCH_WRAP_TRAP_EN.
module fetch_unit #(
    parameter int PC_W  = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             br_taken,
    input  logic             jmp,
    input  logic [IDX_W-1:0] br_idx,
    input  logic             tbl_we,
    input  logic [IDX_W-1:0] tbl_waddr,
    input  logic [PC_W-1:0]  tbl_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef FETCH_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int unsigned TBL_N = 2 ** IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic [PC_W-1:0] r_tbl [TBL_N];
    logic            w_redirect;
    logic            w_tbl_wr;

    assign w_redirect = jmp | br_taken;
    // The table is frozen while a program runs.
    assign w_tbl_wr   = tbl_we && (r_state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_DONE;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_redirect) begin
                    w_pc_nxt = r_tbl[br_idx];
                end else if (TRAP_EN && (&r_pc)) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
                w_err_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TBL_N; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (w_tbl_wr) begin
            r_tbl[tbl_waddr] <= tbl_wdata;
        end
    end

    assign pc       = r_pc;
    assign pc_valid = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign err      = r_err;

endmodule
